// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, owner/state encodings and the downloader
// FIFO entry layout used by the RAM port arbiter and its write buffer.
package ram_arb_pkg;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DL,
    OWN_CPU,
    OWN_VID
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dl_entry_t;

  // Builds a flat FIFO word from a downloader address/data pair.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] d);
    dl_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

endpackage

// File: rtl/ram_arb_dl_fifo.sv
// ram_arb_dl_fifo: small synchronous FIFO buffering downloader writes.
// The head entry is held in a register so the arbiter can latch it
// directly when it grants the port. A push while full is only accepted
// when a pop happens in the same cycle; otherwise o_drop pulses.
module ram_arb_dl_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_drop
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ENTRY_W-1:0] r_head;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_push_ok;
  logic [AW-1:0]      w_rd_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_push_ok = i_push & (~w_full | i_pop);
  assign w_rd_next = r_rd_ptr + AW'(1);

  // Storage write; no reset needed, occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers and occupancy count; push and pop in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_push_ok, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered head: refilled from storage on a pop, or bypassed from
  // the incoming word when the FIFO is (or is about to become) empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head <= '0;
    end else if (i_pop && (r_count > CNT_ONE)) begin
      r_head <= r_mem[w_rd_next];
    end else if (w_push_ok && (w_empty || (i_pop && (r_count == CNT_ONE)))) begin
      r_head <= i_entry;
    end
  end

  assign o_head  = r_head;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_drop  = i_push & w_full & ~i_pop;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one SDRAM req/ack port between the ROM/PRG
// downloader (buffered, top priority), the Z80 CPU and the video fetcher.
// Video normally beats the CPU, but a CPU that has watched STARVE_MAX
// video grants in a row wins next. The CPU is held off while a download
// is active.
// Optional build macro: RAM_ARB_ROM_WP_EN -- once rom_done is set, CPU
// writes below ROM_SIZE are acknowledged without touching RAM.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                DL_FIFO_DEPTH = 4,
  parameter int                STARVE_MAX    = 3,
  parameter logic [ADDR_W-1:0] ROM_SIZE      = 25'h10000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  input  logic              rom_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_dout,
  output logic              vid_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ack,
  output logic              dl_busy,
  output logic              dl_overflow
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t            r_state;
  owner_t            r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_cpu_ack;
  logic              r_vid_ack;
  logic [DATA_W-1:0] r_cpu_dout;
  logic [DATA_W-1:0] r_vid_dout;
  logic [SW-1:0]     r_starve;
  logic              r_overflow;
  logic              r_wp;

  logic [ENTRY_W-1:0] w_fifo_head;
  dl_entry_t          w_head;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_fifo_drop;
  logic               w_fifo_pop;
  logic               w_idle;
  logic               w_cpu_hi;
  logic               w_cpu_lo;
  logic               w_grant_dl;
  logic               w_grant_cpu;
  logic               w_grant_vid;
  logic               w_rom_hit;

  ram_arb_dl_fifo #(
    .DEPTH (DL_FIFO_DEPTH)
  ) u_dl_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (dl_wr),
    .i_entry (pack_entry(dl_addr, dl_data)),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_drop  (w_fifo_drop)
  );

  assign w_head = dl_entry_t'(w_fifo_head);

  // The buffered downloader entry retires when its RAM access completes.
  assign w_fifo_pop = (r_state == ST_WAIT) & mem_ack & (r_owner == OWN_DL);

  // Priority: FIFO, starved CPU, video, CPU. CPU never wins during a download.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_cpu_hi    = cpu_req & ~dl_active & (r_starve == STARVE_LIM);
  assign w_cpu_lo    = cpu_req & ~dl_active;
  assign w_grant_dl  = w_idle & ~w_fifo_empty;
  assign w_grant_cpu = w_idle & w_fifo_empty & (w_cpu_hi | (~vid_req & w_cpu_lo));
  assign w_grant_vid = w_idle & w_fifo_empty & ~w_cpu_hi & vid_req;

`ifdef RAM_ARB_ROM_WP_EN
  assign w_rom_hit = cpu_we & rom_done & (cpu_addr < ROM_SIZE);
`else
  logic w_unused;
  assign w_rom_hit = 1'b0;
  assign w_unused  = rom_done ^ (|ROM_SIZE);
`endif

  // Arbitration FSM: latch winner in IDLE, raise mem_req in ISSUE, hold until mem_ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_NONE;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_cpu_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_cpu_dout <= '0;
      r_vid_dout <= '0;
      r_wp       <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_dl) begin
            r_owner    <= OWN_DL;
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_head.addr;
            r_mem_din  <= w_head.data;
            r_wp       <= 1'b0;
            r_state    <= ST_ISSUE;
          end else if (w_grant_cpu) begin
            r_owner    <= OWN_CPU;
            r_mem_we   <= cpu_we;
            r_mem_addr <= cpu_addr;
            r_mem_din  <= cpu_din;
            r_wp       <= w_rom_hit;
            r_state    <= ST_ISSUE;
          end else if (w_grant_vid) begin
            r_owner    <= OWN_VID;
            r_mem_we   <= 1'b0;
            r_mem_addr <= vid_addr;
            r_wp       <= 1'b0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_wp) begin
            // Protected ROM write: complete locally, RAM never sees it.
            r_cpu_ack <= 1'b1;
            r_wp      <= 1'b0;
            r_owner   <= OWN_NONE;
            r_state   <= ST_IDLE;
          end else begin
            r_mem_req <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_owner == OWN_CPU) begin
              r_cpu_ack  <= 1'b1;
              r_cpu_dout <= mem_dout;
            end
            if (r_owner == OWN_VID) begin
              r_vid_ack  <= 1'b1;
              r_vid_dout <= mem_dout;
            end
            r_owner <= OWN_NONE;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_owner   <= OWN_NONE;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Starve counter: video grants seen while the CPU keeps asking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (!cpu_req || w_grant_cpu) begin
      r_starve <= '0;
    end else if (w_grant_vid && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Sticky flag for a downloader write lost to a full buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_dout    = r_cpu_dout;
  assign vid_ack     = r_vid_ack;
  assign vid_dout    = r_vid_dout;
  assign dl_overflow = r_overflow;
  assign dl_busy     = ~w_fifo_empty | (r_owner == OWN_DL);
  assign cpu_wait    = reset_n & ((cpu_req & ~r_cpu_ack) | dl_active);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench with a RAM responder and a
// scoreboard of expected RAM accesses, a CPU vector table and hand
// sequences for the multi-cycle corner cases.
module tb_ram_port_arbiter;

`ifdef RAM_ARB_ROM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_wr, rom_done;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_req, cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack, cpu_wait;
  logic        vid_req;
  logic [24:0] vid_addr;
  logic [7:0]  vid_dout;
  logic        vid_ack;
  logic        mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_ack;
  logic        dl_busy, dl_overflow;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .rom_done(rom_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .dl_busy(dl_busy), .dl_overflow(dl_overflow)
  );

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
  } acc_t;

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic        rom_done;
    logic [7:0]  rd;
    int          to_ram;
    int          lat;
  } vec_t;

  acc_t        exp_q[$];
  vec_t        vecs[7];
  int          total = 0;
  int          bad = 0;
  int          acc_seen = 0;
  bit          ack_en;
  int          ack_delay;
  int          ack_cnt;
  bit          late_ack;
  logic [7:0]  rd_data;
  logic        prev_req;
  logic [24:0] hold_addr;
  logic        hold_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic acc_t mk(input logic we, input logic [24:0] a, input logic [7:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.din = d;
    return e;
  endfunction

  // One clock: sample just after the edge, score new accesses, run the RAM model.
  task automatic tick();
    acc_t e;
    @(posedge clk);
    #1;
    if (mem_req && prev_req) begin
      check("mem_addr_hold", mem_addr, hold_addr);
      check("mem_we_hold", mem_we, hold_we);
    end
    if (mem_req && !prev_req) begin
      acc_seen++;
      hold_addr = mem_addr;
      hold_we   = mem_we;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_unexpected: got addr=%0h we=%0b expected no access", mem_addr, mem_we);
      end else begin
        e = exp_q.pop_front();
        check("mem_we", mem_we, e.we);
        check("mem_addr", mem_addr, e.addr);
        if (e.we) check("mem_din", mem_din, e.din);
        $display("access %0d: we=%0b addr=%0h din=%0h", acc_seen, mem_we, mem_addr, mem_din);
      end
    end
    prev_req = mem_req;
    if (late_ack) begin
      mem_ack  = 1'b1;
      late_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && ack_en) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_dout = rd_data;
        ack_cnt  = 0;
      end
    end
    if (!mem_req) ack_cnt = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_cpu_ack(input string name, input int max);
    int n;
    n = 0;
    while (!cpu_ack && n < max) begin
      tick();
      n++;
    end
    if (!cpu_ack) timeout(name);
  endtask

  task automatic wait_not_busy(input string name, input int max);
    int n;
    n = 0;
    while (dl_busy && n < max) begin
      tick();
      n++;
    end
    if (dl_busy) timeout(name);
  endtask

  task automatic wait_mem_req(input string name, input int max);
    int n;
    n = 0;
    while (!mem_req && n < max) begin
      tick();
      n++;
    end
    if (!mem_req) timeout(name);
  endtask

  initial begin
    int  n, nv, base;
    bit  flag;

    vecs[0] = '{we:1'b0, addr:25'h18995, din:8'h00, rom_done:1'b1, rd:8'h5A, to_ram:1, lat:5};
    vecs[1] = '{we:1'b1, addr:25'h00100, din:8'h11, rom_done:1'b1, rd:8'h00, to_ram:(WP ? 0 : 1), lat:(WP ? 2 : 5)};
    vecs[2] = '{we:1'b1, addr:25'h10100, din:8'h22, rom_done:1'b1, rd:8'h00, to_ram:1, lat:5};
    vecs[3] = '{we:1'b1, addr:25'h00100, din:8'h33, rom_done:1'b0, rd:8'h00, to_ram:1, lat:5};
    vecs[4] = '{we:1'b0, addr:25'h00100, din:8'h00, rom_done:1'b1, rd:8'hA5, to_ram:1, lat:5};
    vecs[5] = '{we:1'b1, addr:25'h0FFFF, din:8'h44, rom_done:1'b1, rd:8'h00, to_ram:(WP ? 0 : 1), lat:(WP ? 2 : 5)};
    vecs[6] = '{we:1'b1, addr:25'h10000, din:8'h55, rom_done:1'b1, rd:8'h00, to_ram:1, lat:5};

    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    rom_done = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0; mem_dout = '0; mem_ack = 1'b0;
    ack_en = 1'b1; ack_delay = 3; ack_cnt = 0; late_ack = 1'b0; rd_data = 8'h00;
    prev_req = 1'b0; hold_addr = '0; hold_we = 1'b0;

    // Reset with CPU and video both requesting; video wins the first grant.
    cpu_req = 1'b1; cpu_addr = 25'h01111; vid_req = 1'b1; vid_addr = 25'h00444;
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_vid_ack", vid_ack, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_vid_dout", vid_dout, 0);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_dl_busy", dl_busy, 0);
    check("rst_dl_overflow", dl_overflow, 0);
    exp_q.push_back(mk(1'b0, 25'h00444, 8'h00));
    exp_q.push_back(mk(1'b0, 25'h01111, 8'h00));
    rd_data = 8'h3C;
    reset_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 60 && !flag; i++) begin
      tick();
      if (vid_ack) begin
        vid_req = 1'b0;
        check("rst_vid_dout_ack", vid_dout, 8'h3C);
      end
      if (cpu_ack) begin
        cpu_req = 1'b0;
        flag = 1'b1;
      end
    end
    if (!flag) timeout("rst_grants");
    tick();
    check("rst_queue_empty", exp_q.size(), 0);

    // CPU vector table: reads, writes and ROM boundary addresses.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      base = acc_seen;
      rom_done = vecs[v].rom_done;
      rd_data  = vecs[v].rd;
      if (vecs[v].to_ram != 0) exp_q.push_back(mk(vecs[v].we, vecs[v].addr, vecs[v].din));
      cpu_we = vecs[v].we; cpu_addr = vecs[v].addr; cpu_din = vecs[v].din; cpu_req = 1'b1;
      n = 0;
      while (n < 20) begin
        tick();
        n++;
        if (n == 1) check("vec_cpu_wait", cpu_wait, 1);
        if (cpu_ack) break;
      end
      check("vec_ack_latency", n, vecs[v].lat);
      if (!vecs[v].we) check("vec_cpu_dout", cpu_dout, vecs[v].rd);
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      tick();
      check("vec_ram_accesses", acc_seen - base, vecs[v].to_ram);
      check("vec_queue_empty", exp_q.size(), 0);
    end
    rom_done = 1'b0;

    // Download of three bytes with a CPU read pending; CPU waits throughout.
    do_reset();
    base = acc_seen;
    exp_q.push_back(mk(1'b1, 25'h00000, 8'hF3));
    exp_q.push_back(mk(1'b1, 25'h00001, 8'hAF));
    exp_q.push_back(mk(1'b1, 25'h00002, 8'hC3));
    exp_q.push_back(mk(1'b0, 25'h01234, 8'h00));
    dl_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h01234;
    ack_delay = 3; rd_data = 8'h77;
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dl_wr = 1'b1; dl_addr = 25'(i);
      dl_data = (i == 0) ? 8'hF3 : (i == 1) ? 8'hAF : 8'hC3;
      tick();
      if (!cpu_wait) flag = 1'b1;
    end
    dl_wr = 1'b0;
    check("dl_busy_during", dl_busy, 1);
    n = 0;
    while (dl_busy && n < 100) begin
      tick();
      n++;
      if (!cpu_wait) flag = 1'b1;
    end
    if (dl_busy) timeout("dl_drain");
    check("dl_cpu_wait_held", flag, 0);
    check("dl_writes_done", acc_seen - base, 3);
    check("dl_no_overflow", dl_overflow, 0);
    dl_active = 1'b0;
    wait_cpu_ack("dl_cpu_after", 40);
    check("dl_cpu_dout", cpu_dout, 8'h77);
    cpu_req = 1'b0;
    tick();
    check("dl_queue_empty", exp_q.size(), 0);

    // Six back-to-back strobes with mem_ack withheld: four survive, overflow sticks.
    do_reset();
    base = acc_seen;
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 25'h00100 + 25'(i), 8'h10 + 8'(i)));
    dl_active = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1'b1; dl_addr = 25'h00100 + 25'(i); dl_data = 8'h10 + 8'(i);
      tick();
    end
    dl_wr = 1'b0;
    tick();
    check("ovf_set", dl_overflow, 1);
    ack_en = 1'b1;
    wait_not_busy("ovf_drain", 100);
    check("ovf_writes", acc_seen - base, 4);
    check("ovf_sticky", dl_overflow, 1);
    check("ovf_queue_empty", exp_q.size(), 0);
    dl_active = 1'b0;
    do_reset();
    check("ovf_reset_clear", dl_overflow, 0);

    // Push on the very cycle a full FIFO pops: both honoured, no overflow.
    base = acc_seen;
    ack_delay = 3;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b1, 25'h00200 + 25'(i), 8'h20 + 8'(i)));
    dl_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dl_wr = 1'b1; dl_addr = 25'h00200 + 25'(i); dl_data = 8'h20 + 8'(i);
      tick();
    end
    dl_wr = 1'b0;
    n = 0;
    while (!mem_ack && n < 20) begin
      tick();
      n++;
    end
    if (!mem_ack) timeout("full_pop_ack");
    dl_wr = 1'b1; dl_addr = 25'h00204; dl_data = 8'h24;
    tick();
    dl_wr = 1'b0;
    check("full_pop_no_ovf", dl_overflow, 0);
    wait_not_busy("full_pop_drain", 100);
    check("full_pop_writes", acc_seen - base, 5);
    check("full_pop_queue_empty", exp_q.size(), 0);
    dl_active = 1'b0;

    // Starvation: video held continuously, CPU gets the fourth grant.
    do_reset();
    ack_delay = 1; rd_data = 8'h5A;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 25'h00777, 8'h00));
    exp_q.push_back(mk(1'b0, 25'h18995, 8'h00));
    vid_req = 1'b1; vid_addr = 25'h00777;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h18995;
    nv = 0;
    flag = 1'b0;
    for (int i = 0; i < 100 && !flag; i++) begin
      tick();
      if (vid_ack) begin
        nv++;
        check("starve_vid_dout", vid_dout, 8'h5A);
      end
      if (cpu_ack) begin
        check("starve_cpu_dout", cpu_dout, 8'h5A);
        cpu_req = 1'b0; vid_req = 1'b0;
        flag = 1'b1;
      end
    end
    if (!flag) timeout("starve_cpu_ack");
    check("starve_vid_grants", nv, 3);
    tick();
    tick();
    check("starve_queue_empty", exp_q.size(), 0);

    // Download starts while a CPU write is in flight; it completes, then CPU is held off.
    do_reset();
    ack_delay = 6;
    exp_q.push_back(mk(1'b1, 25'h20000, 8'h33));
    exp_q.push_back(mk(1'b1, 25'h00300, 8'h44));
    exp_q.push_back(mk(1'b1, 25'h20000, 8'h33));
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h20000; cpu_din = 8'h33;
    wait_mem_req("mid_cpu_req", 20);
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h00300; dl_data = 8'h44;
    tick();
    dl_wr = 1'b0;
    wait_cpu_ack("mid_cpu_ack", 40);
    check("mid_ack_in_dl", dl_active, 1);
    wait_not_busy("mid_drain", 60);
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req) flag = 1'b1;
    end
    check("mid_cpu_held", flag, 0);
    dl_active = 1'b0;
    wait_cpu_ack("mid_cpu_second", 40);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("mid_queue_empty", exp_q.size(), 0);

    // Reset mid-access drops mem_req; a late mem_ack in IDLE is ignored.
    ack_en = 1'b0; ack_delay = 2;
    exp_q.push_back(mk(1'b0, 25'h00555, 8'h00));
    cpu_req = 1'b1; cpu_addr = 25'h00555;
    wait_mem_req("rstmid_req", 20);
    reset_n = 1'b0; cpu_req = 1'b0;
    tick();
    check("rstmid_mem_req", mem_req, 0);
    reset_n = 1'b1;
    late_ack = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack || vid_ack || mem_req) flag = 1'b1;
    end
    check("late_ack_ignored", flag, 0);
    ack_en = 1'b1; rd_data = 8'h9E;
    exp_q.push_back(mk(1'b0, 25'h00888, 8'h00));
    vid_req = 1'b1; vid_addr = 25'h00888;
    n = 0;
    while (!vid_ack && n < 30) begin
      tick();
      n++;
    end
    if (!vid_ack) timeout("rstmid_vid_ack");
    check("rstmid_vid_dout", vid_dout, 8'h9E);
    vid_req = 1'b0;
    tick();
    check("rstmid_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single external RAM port (SDRAM controller req/ack interface) between three requesters: the ROM/PRG downloader, the Z80 CPU and the video fetcher.
- Downloader write strobes are single-cycle and cannot be stalled, so they are buffered in a small FIFO and drained with top priority.
- Holds the CPU in wait while a download is active, and optionally write-protects the ROM region once boot ROM load completes.
- Sits between downloader/CPU/video and the SDRAM controller.

Parameters:
- DL_FIFO_DEPTH, 4, downloader write buffer entries (power of two, >=2).
- STARVE_MAX, 3, consecutive video grants after which a pending CPU request beats video.
- ROM_SIZE, 25'h10000, byte size of ROM region starting at address 0 (used by the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- dl_active  in  1  download in progress (downloader "downloading")
- dl_wr  in  1  one-cycle write strobe from downloader
- dl_addr  in  25  downloader byte address
- dl_data  in  8  downloader write data
- rom_done  in  1  boot ROM load complete (sticky)
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  25  CPU byte address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  stall to CPU
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  25  video byte address
- vid_dout  out  8  video read data, valid with vid_ack
- vid_ack  out  1  one-cycle completion pulse
- mem_req  out  1  RAM request, held until mem_ack
- mem_we  out  1  RAM write enable
- mem_addr  out  25  RAM address
- mem_din  out  8  RAM write data
- mem_dout  in  8  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completion pulse
- dl_busy  out  1  FIFO non-empty or downloader access in flight
- dl_overflow  out  1  sticky: a dl_wr was dropped because the FIFO was full

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0; cpu_dout and vid_dout = 8'h00; state IDLE; FIFO emptied; starve counter 0; dl_overflow cleared.
- Reset asserted mid-access drops mem_req immediately. A late mem_ack in IDLE is ignored.
- FIFO push:
  - On dl_wr, push {dl_addr, dl_data}.
  - If full, drop the write and set dl_overflow (stays set until reset).
  - Push and pop in the same cycle are both honoured, including when full.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: evaluate requests in priority order; the winner's addr/data/we are latched; go to ISSUE.
  1. FIFO non-empty.
  2. cpu_req, if the starve counter equals STARVE_MAX and dl_active=0.
  3. vid_req.
  4. cpu_req, if dl_active=0.
- ISSUE: drive mem_req=1 with the latched fields; go to WAIT. Latency: mem_req rises 2 cycles after the request is first visible in IDLE.
- WAIT:
  - Hold mem_req and all mem_* fields stable until mem_ack.
  - On mem_ack: deassert mem_req the next cycle; pulse the owner's ack for one cycle with mem_dout registered into its dout; pop the FIFO if the owner is dl; return to IDLE.
  - Back-to-back accesses therefore have one idle cycle between them.
- Starve counter:
  - Increments on each video grant while cpu_req=1.
  - Clears on a CPU grant, or when cpu_req=0.
  - Saturates at STARVE_MAX.
- cpu_wait = cpu_req & ~cpu_ack, OR dl_active. It is combinational from registered state plus inputs.
- The CPU is never granted while dl_active=1. A CPU access already in flight when dl_active rises completes normally.
- Requester rule: req must drop in the cycle after its ack; if still high, it is a new request.
- dl_busy = FIFO non-empty, OR dl owns the port.
- Addresses pass through unmodified; no width conversion.

Optional Feature:
- Macro: RAM_ARB_ROM_WP_EN.
- With the macro: a CPU write with cpu_addr < ROM_SIZE while rom_done=1 is granted normally but generates no mem_req. cpu_ack pulses 2 cycles after grant. Downloader writes are never protected.
- Without the macro: no address check; all CPU writes reach RAM.

Decomposition:
- Package ram_arb_pkg:
  - owner enum {OWN_NONE, OWN_DL, OWN_CPU, OWN_VID}
  - FSM state enum
  - ADDR_W=25, DATA_W=8
  - FIFO entry struct {addr, data}
- Sub-module ram_arb_dl_fifo: synchronous FIFO with push/pop/full/empty and registered head output.

Test Plan:
- Reset with cpu_req=1 and vid_req=1 held → all outputs 0 while reset_n=0; the first grant after release goes to vid.
- dl_active=1 and 3 consecutive dl_wr to 0x0000..0x0002 with data 0xF3,0xAF,0xC3, mem_ack 3 cycles after each mem_req → three writes in order, cpu_wait=1 throughout, dl_busy falls after the third ack, dl_overflow=0.
- 6 dl_wr on back-to-back cycles with DL_FIFO_DEPTH=4 and mem_ack withheld → dl_overflow=1; only 4 entries (4, or 5 if one is popped) reach RAM in order.
- cpu_req read 0x18995 and vid_req asserted continuously with mem_ack returning 0x5A → video wins 3 grants, the 4th grant goes to CPU, cpu_dout=0x5A with cpu_ack.
- dl_active rises during a CPU access in WAIT → that access completes with cpu_ack; no further CPU grant until dl_active=0 and the FIFO drains.
- RAM_ARB_ROM_WP_EN defined, rom_done=1, CPU write to 0x00100 → no mem_req, cpu_ack pulses; the same write to 0x10100 reaches RAM with mem_we=1.
